// File: rtl/washer_key_ctrl.sv
// washer_key_ctrl
// Key-event controller for the washer front panel. Accepts debounced key
// levels, arbitrates simultaneous presses (lowest index wins), classifies
// each accepted press as short or long, and hands exactly one event per
// press to the washer control FSM over a valid/ack handshake.
//
// Ports:
//   clock      system clock, rising edge
//   rst_n      asynchronous active-low reset
//   key_lvl    debounced key levels, 1 = pressed
//   evt_ack    consumer accepts the pending event
//   evt_valid  event pending (registered)
//   evt_code   index of the key that produced the event (registered)
//   evt_long   1 = long press, 0 = short press (registered)
//   busy       high whenever the controller is not idle (registered)
module washer_key_ctrl #(
  parameter int NKEYS       = 4,
  parameter int CODE_W      = 2,
  parameter int LONG_CYCLES = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [NKEYS-1:0]  key_lvl,
  input  logic              evt_ack,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_long,
  output logic              busy
);

  localparam int CNT_W = $clog2(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_ACK = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  logic [CODE_W-1:0]   own_q, own_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NKEYS-1:0]    key_prev_q, key_prev_d;
  logic                evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0]   evt_code_q, evt_code_d;
  logic                evt_long_q, evt_long_d;
  logic                busy_q, busy_d;

  logic [NKEYS-1:0]    rise;
  logic [CODE_W-1:0]   cap_idx;
  logic                own_lvl;

  // Rise detection and lowest-index priority pick. Scanning downwards
  // leaves the lowest set bit as the final assignment.
  always_comb begin
    rise    = key_lvl & ~key_prev_q;
    cap_idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (rise[i]) cap_idx = CODE_W'(i);
    end
  end

  assign own_lvl = key_lvl[own_q];

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    own_d       = own_q;
    hold_cnt_d  = hold_cnt_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_long_d  = evt_long_q;
    // key_prev tracks every key in every state, so presses that arrive
    // while busy are consumed here and never reported later.
    key_prev_d  = key_lvl;

    case (state_q)
      IDLE: begin
        if (|rise) begin
          own_d      = cap_idx;
          hold_cnt_d = '0;
          state_d    = HELD;
        end
      end
      HELD: begin
        // Release wins over the long threshold on the same edge.
        if (!own_lvl) begin
          evt_code_d  = own_q;
          evt_long_d  = 1'b0;
          evt_valid_d = 1'b1;
          ret_d       = IDLE;
          state_d     = WAIT_ACK;
        end else if (hold_cnt_q == LONG_LAST) begin
          evt_code_d  = own_q;
          evt_long_d  = 1'b1;
          evt_valid_d = 1'b1;
          ret_d       = RELEASE;
          state_d     = WAIT_ACK;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (evt_ack) begin
          evt_valid_d = 1'b0;
          state_d     = ret_q;
        end
      end
      RELEASE: begin
        // Swallow the release of a long press so it yields no second event.
        if (!own_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      own_q       <= '0;
      hold_cnt_q  <= '0;
      // All ones: keys already held through reset never register a rise.
      key_prev_q  <= '1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_long_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      own_q       <= own_d;
      hold_cnt_q  <= hold_cnt_d;
      key_prev_q  <= key_prev_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_long_q  <= evt_long_d;
      busy_q      <= busy_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_long  = evt_long_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_washer_key_ctrl.sv
// Directed bench for washer_key_ctrl with an expected-event scoreboard.
module tb_washer_key_ctrl;

  logic       clock;
  logic       rst_n;
  logic [3:0] key_lvl;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_long;
  logic       busy;

  typedef struct packed {
    logic [1:0] code;
    logic       lng;
  } ev_t;

  ev_t sb_q[$];
  int  tests;
  int  fails;

  washer_key_ctrl #(
    .NKEYS(4),
    .CODE_W(2),
    .LONG_CYCLES(8)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .key_lvl  (key_lvl),
    .evt_ack  (evt_ack),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_long (evt_long),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] code, input logic lng);
    ev_t e;
    e.code = code;
    e.lng  = lng;
    sb_q.push_back(e);
  endtask

  // Called when the DUT should be presenting an event right now.
  task automatic sb_check(input string tag);
    ev_t e;
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_sb: observed empty scoreboard expected pending entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_code"}, 32'(evt_code), 32'(e.code));
      chk({tag, "_long"}, 32'(evt_long), 32'(e.lng));
      $display("[TB] event %s code=%0d long=%0d", tag, evt_code, evt_long);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    key_lvl = 4'b0001;
    evt_ack = 1'b0;

    // --- Reset with key0 held through it ---
    repeat (2) tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code",  32'(evt_code),  32'd0);
    chk("rst_long",  32'(evt_long),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1_held_nobusy",  32'(busy),      32'd0);
      chk("s1_held_novalid", 32'(evt_valid), 32'd0);
    end
    key_lvl = 4'b0000;
    tick();
    key_lvl = 4'b0001;
    tick();
    chk("s1_capture_busy", 32'(busy), 32'd1);
    tick();
    tick();
    key_lvl = 4'b0000;
    push_ev(2'd0, 1'b0);
    begin
      int n;
      n = 0;
      tick();
      while (!evt_valid && n < 20) begin
        tick();
        n++;
      end
    end
    sb_check("s1");
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("s1_ack_valid", 32'(evt_valid), 32'd0);
    chk("s1_ack_busy",  32'(busy),      32'd0);

    // --- Key2 short press with ack tied high ---
    key_lvl = 4'b0100;
    tick();
    chk("s2_capture_busy",  32'(busy),      32'd1);
    chk("s2_capture_valid", 32'(evt_valid), 32'd0);
    tick();
    tick();
    chk("s2_hold_valid", 32'(evt_valid), 32'd0);
    key_lvl = 4'b0000;
    evt_ack = 1'b1;
    push_ev(2'd2, 1'b0);
    tick();
    sb_check("s2");
    chk("s2_busy_during", 32'(busy), 32'd1);
    tick();
    chk("s2_valid_1cyc", 32'(evt_valid), 32'd0);
    chk("s2_busy_drop",  32'(busy),      32'd0);
    tick();
    chk("s2_valid_stay0", 32'(evt_valid), 32'd0);
    evt_ack = 1'b0;

    // --- Key1 and key3 rise together: key1 wins, key3 is lost ---
    key_lvl = 4'b1010;
    tick();
    chk("s3_capture_busy", 32'(busy), 32'd1);
    tick();
    tick();
    key_lvl = 4'b1000;
    push_ev(2'd1, 1'b0);
    tick();
    sb_check("s3");
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("s3_ack_valid", 32'(evt_valid), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("s3_k3_novalid", 32'(evt_valid), 32'd0);
      chk("s3_k3_nobusy",  32'(busy),      32'd0);
    end
    key_lvl = 4'b0000;
    tick();
    key_lvl = 4'b1000;
    tick();
    chk("s3_k3_capture", 32'(busy), 32'd1);
    tick();
    key_lvl = 4'b0000;
    push_ev(2'd3, 1'b0);
    tick();
    sb_check("s3_k3");
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("s3_k3_ack", 32'(evt_valid), 32'd0);

    // --- Key0 long press held for 20 edges ---
    key_lvl = 4'b0001;
    tick();  // capture edge
    push_ev(2'd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) chk("s4_not_yet", 32'(evt_valid), 32'd0);
      else       sb_check("s4_long");
    end
    evt_ack = 1'b1;
    tick();  // edge 9
    evt_ack = 1'b0;
    chk("s4_ack_valid", 32'(evt_valid), 32'd0);
    chk("s4_ack_busy",  32'(busy),      32'd1);
    for (int k = 10; k < 20; k++) begin
      tick();
      chk("s4_release_novalid", 32'(evt_valid), 32'd0);
      chk("s4_release_busy",    32'(busy),      32'd1);
    end
    key_lvl = 4'b0000;
    tick();
    chk("s4_busy_drop", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_no_second_ev", 32'(evt_valid), 32'd0);
    end

    // --- Key released exactly on the long threshold edge: short ---
    key_lvl = 4'b0010;
    tick();  // capture edge
    for (int k = 1; k < 8; k++) tick();
    key_lvl = 4'b0000;
    push_ev(2'd1, 1'b0);
    tick();  // edge 8 samples the release
    sb_check("s4b_edge_short");
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("s4b_ack_busy", 32'(busy), 32'd0);

    // --- Short event with ack delayed 5 cycles, then stray ack ---
    key_lvl = 4'b0010;
    tick();
    tick();
    tick();
    key_lvl = 4'b0000;
    push_ev(2'd1, 1'b0);
    tick();
    sb_check("s5");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s5_hold_valid", 32'(evt_valid), 32'd1);
      chk("s5_hold_code",  32'(evt_code),  32'd1);
      chk("s5_hold_long",  32'(evt_long),  32'd0);
    end
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("s5_ack_valid", 32'(evt_valid), 32'd0);
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    tick();
    chk("s5_idle_ack_valid", 32'(evt_valid), 32'd0);
    chk("s5_idle_ack_busy",  32'(busy),      32'd0);

    // --- Reset during WAIT_ACK drops the event ---
    key_lvl = 4'b0100;
    tick();
    tick();
    key_lvl = 4'b0000;
    tick();
    chk("s6_pre_valid", 32'(evt_valid), 32'd1);
    key_lvl = 4'b0001;
    rst_n   = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(evt_valid), 32'd0);
    chk("s6_rst_code",  32'(evt_code),  32'd0);
    chk("s6_rst_long",  32'(evt_long),  32'd0);
    chk("s6_rst_busy",  32'(busy),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("s6_held_novalid", 32'(evt_valid), 32'd0);
      chk("s6_held_nobusy",  32'(busy),      32'd0);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/washer_key_ctrl.md
# washer_key_ctrl

Key-event controller for the washer front panel. Takes the debounced key levels produced by the per-key debounce stages and arbitrates between simultaneous presses. It classifies each accepted press as short or long and delivers exactly one event per press to the washer control FSM over a valid/ack handshake. It sits between the debounce stages and the main washer state machine.

## Interface
- `NKEYS`, 4, number of debounced key inputs.
- `CODE_W`, 2, width of the key index output; must satisfy 2^CODE_W >= NKEYS.
- `LONG_CYCLES`, 8, clock edges a key must stay high after capture to be classified long; must be >= 2.

- `clock`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_lvl`  in  NKEYS  debounced key levels, 1 = pressed; synchronous to `clock`.
- `evt_ack`  in  1  consumer accepts the current event.
- `evt_valid`  out  1  event pending; registered.
- `evt_code`  out  CODE_W  index of the key that generated the event; registered.
- `evt_long`  out  1  1 = long press, 0 = short press; registered.
- `busy`  out  1  registered; high whenever the state is not IDLE.

## Operation
- `key_prev` is a register that samples `key_lvl` on every edge, in every state.
  - A rise is defined as `key_lvl & ~key_prev`.
  - Reset value of `key_prev` is all ones, so keys held through reset are never reported until released and re-pressed.
- The state machine has four states: IDLE, HELD, WAIT_ACK and RELEASE.
- IDLE:
  - If any rise bit is set, capture the lowest set index into `own`, clear `hold_cnt`, and go to HELD.
  - Higher-index rises in the same cycle are discarded.
- HELD, when `key_lvl[own]` = 0:
  - Load `evt_code`=`own`, `evt_long`=0, `evt_valid`=1.
  - Set `ret`=IDLE and go to WAIT_ACK.
- HELD, when `key_lvl[own]` = 1 and `hold_cnt` = LONG_CYCLES-1:
  - Load `evt_code`=`own`, `evt_long`=1, `evt_valid`=1.
  - Set `ret`=RELEASE and go to WAIT_ACK.
- HELD, when `key_lvl[own]` = 1 otherwise: `hold_cnt`++.
  - Width is clog2(LONG_CYCLES); the counter never wraps because it is bounded by the long check.
- WAIT_ACK:
  - `evt_valid`, `evt_code` and `evt_long` are held stable.
  - On an edge with `evt_ack`=1: clear `evt_valid` and go to `ret`.
- RELEASE: when `key_lvl[own]` = 0, go to IDLE. This ensures a long press yields no second event on release.
- Rises of any key while not in IDLE are lost. `key_prev` still tracks them, so a key still held on return to IDLE is not captured.
- `evt_ack` is ignored while `evt_valid`=0.
- Only one event can be outstanding; there is no queue.

## Timing
- Reset (asynchronous, immediate) sets `evt_valid`=0, `evt_code`=0, `evt_long`=0, `busy`=0, state=IDLE, `hold_cnt`=0, `own`=0, and `key_prev`=all ones.
- Reset applied mid-event drops the event without an ack.
- Capture: the edge that samples the rise moves the state to HELD; `busy` is high in the following cycle.
- Short event: `evt_valid` rises in the cycle after the edge that samples `key_lvl[own]`=0.
- Long event: `evt_valid` rises after the LONG_CYCLES-th edge following the capture edge, provided the key stays high.
  - A key released exactly on that edge (sampled 0) produces a short event.
- Ack: `evt_ack` sampled high at an edge while `evt_valid`=1 causes `evt_valid` to read 0 in the next cycle.
  - Zero-wait ack (ack already high when valid rises) completes at the first edge where valid is 1; minimum event width is 1 cycle.
- `busy` falls in the cycle after the transition into IDLE.

## Test plan
- Reset released with `key_lvl`=0001 held: no event.
  - Then release and re-press key0 for 3 cycles → one short event with code=0, long=0.
- Key2 high for 3 cycles, then low, with `evt_ack` tied high:
  - `evt_valid` is high for exactly 1 cycle, one cycle after the fall, with code=2, long=0.
  - `busy` drops 1 cycle after that.
- Key1 and key3 rise on the same edge:
  - One event with code=1.
  - Key3 is still held after key1's event completes; no event for key3 until it is released and re-pressed.
- Key0 held for 20 cycles (LONG_CYCLES=8):
  - `evt_valid` with long=1 appears 8 edges after capture.
  - Acked immediately; no event on release; `busy` stays high until 1 cycle after release.
- Short event with `evt_ack` delayed 5 cycles:
  - code, long and valid are stable throughout the wait.
  - An `evt_ack` pulse applied while idle has no effect.
- Assert `rst_n`=0 during WAIT_ACK: all outputs read 0 immediately. After reset, a held key produces no event.
